ndma_rd_engine: RTL

//  OBI read engine of the NanoDMA datapath. It issues word reads from a source address range
//  and pushes each returned beat into the ndma data FIFO, which feeds the write side.
//  It limits outstanding requests so every read already in flight has a guaranteed FIFO slot.

---
 rtl/ndma_pkg.sv | 18 +
 rtl/ndma_rd_engine.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ndma_pkg.sv
// Shared types and constants for the NanoDMA datapath.
package ndma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } ndma_rd_state_e;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned BeatBytes    = ObiDataWidth / 8;

  function automatic int unsigned beat_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ndma_rd_engine.sv
// OBI read engine: issues word reads over a source range and pushes each beat into the data FIFO.
// Optional bus-error handling is enabled by defining NDMA_RD_ERR_EN.
module ndma_rd_engine
  import ndma_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxTxSize      = 256,
  parameter int unsigned FifoDepth      = 1,
  parameter int unsigned MaxOutstanding = 2,
  localparam int unsigned TxCntBits     = $clog2(MaxTxSize) + 1,
  localparam int unsigned FifoCntBits   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1,
  localparam int unsigned OutCntBits    = $clog2(MaxOutstanding + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic [ObiAddrWidth-1:0] src_addr_i,
  input  logic [TxCntBits-1:0]    len_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    obi_req_o,
  input  logic                    obi_gnt_i,
  output logic [ObiAddrWidth-1:0] obi_addr_o,
  output logic                    obi_we_o,
  output logic [DataWidth/8-1:0]  obi_be_o,
  input  logic                    obi_rvalid_i,
  input  logic [DataWidth-1:0]    obi_rdata_i,
  input  logic                    obi_err_i,
  output logic                    fifo_push_o,
  output logic [DataWidth-1:0]    fifo_data_o,
  input  logic                    fifo_full_i,
  input  logic [FifoCntBits-1:0]  fifo_usage_i
);

  localparam int unsigned AddrStep  = beat_bytes(DataWidth);
  localparam int unsigned SpaceBits = $clog2(FifoDepth + 1) + 1;

  ndma_rd_state_e          state_q, state_d;
  logic [ObiAddrWidth-1:0] addr_q, addr_d;
  logic [TxCntBits-1:0]    remain_q, remain_d;
  logic [OutCntBits-1:0]   out_cnt_q, out_cnt_d;
  logic                    hold_q, hold_d;
  logic                    busy_q, done_q, done_d, err_q, err_d;
  logic [SpaceBits-1:0]    space;
  logic                    req, fire, rsp_ok, rsp_err, push;

`ifndef NDMA_RD_ERR_EN
  logic unused_err;
  assign unused_err = obi_err_i;
`endif

  always_comb begin
    space = '0;
    if (!fifo_full_i && 32'(fifo_usage_i) < FifoDepth) begin
      space = SpaceBits'(FifoDepth - 32'(fifo_usage_i));
    end
    // hold_q keeps a raised request (and its address) alive until granted
    req    = hold_q || (state_q == ISSUE && remain_q != '0
                        && 32'(out_cnt_q) < MaxOutstanding
                        && 32'(out_cnt_q) < 32'(space));
    fire   = req && obi_gnt_i;
    rsp_ok = obi_rvalid_i && (out_cnt_q != '0);
`ifdef NDMA_RD_ERR_EN
    rsp_err = rsp_ok && obi_err_i;
`else
    rsp_err = 1'b0;
`endif
    push   = rsp_ok && !rsp_err;
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    out_cnt_d = out_cnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    hold_d    = req && !obi_gnt_i;

    if (fire) begin
      addr_d = addr_q + ObiAddrWidth'(AddrStep);
      if (remain_q != '0) remain_d = remain_q - 1'b1;
    end
    if (fire && !rsp_ok)      out_cnt_d = out_cnt_q + 1'b1;
    else if (!fire && rsp_ok) out_cnt_d = out_cnt_q - 1'b1;

    if (rsp_err) begin
      err_d    = 1'b1;
      remain_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d  = ISSUE;
            addr_d   = src_addr_i;
            remain_d = len_i;
            err_d    = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        // an error may zero remain_q while a request is still waiting for its grant
        if (remain_d == '0 && !hold_d) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_cnt_d == '0) begin
          state_d = IDLE;
          done_d  = !err_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      remain_q  <= '0;
      out_cnt_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      assert (!(obi_rvalid_i && out_cnt_q == '0))
        else $warning("ndma_rd_engine: rvalid with no read outstanding, beat dropped");
      state_q   <= state_d;
      addr_q    <= addr_d;
      remain_q  <= remain_d;
      out_cnt_q <= out_cnt_d;
      hold_q    <= hold_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign obi_req_o   = req;
  assign obi_addr_o  = addr_q;
  assign obi_we_o    = 1'b0;
  assign obi_be_o    = '1;
  assign fifo_push_o = push;
  assign fifo_data_o = obi_rdata_i;

endmodule
